// File: rtl/qed_dup_issuer_if.sv
// Handshake and result bundle between the instruction-constraint source, the
// duplicate issuer and the core fetch path.
interface qed_dup_issuer_if #(
  parameter int unsigned CNT_W = 4
);
  logic             ena;
  logic [31:0]      ifu_inst;
  logic             ifu_valid;
  logic             ifu_ready;
  logic             exec_dup;
  logic             stall_in;
  logic [31:0]      qed_inst;
  logic             qed_valid;
  logic             qed_is_dup;
  logic             qed_done;
  logic [CNT_W-1:0] orig_cnt;
  logic [CNT_W-1:0] dup_cnt;

  modport master (
    output ena, ifu_inst, ifu_valid, exec_dup, stall_in,
    input  ifu_ready, qed_inst, qed_valid, qed_is_dup, qed_done, orig_cnt, dup_cnt
  );

  modport slave (
    input  ena, ifu_inst, ifu_valid, exec_dup, stall_in,
    output ifu_ready, qed_inst, qed_valid, qed_is_dup, qed_done, orig_cnt, dup_cnt
  );
endinterface

// File: rtl/qed_dup_issuer.sv
// SQED producer: forwards constrained originals to the core, buffers them, then
// replays them as register/memory-remapped duplicates.
module qed_dup_issuer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input logic            clk,
  input logic            rst,
  qed_dup_issuer_if.slave bus
);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  OP_R    = 7'b0110011;
  localparam logic [6:0]  OP_I    = 7'b0010011;
  localparam logic [6:0]  OP_LW   = 7'b0000011;
  localparam logic [6:0]  OP_SW   = 7'b0100011;
  localparam logic [6:0]  OP_CNOP = 7'b1111111;

  typedef enum logic [1:0] {ORIG, DUP, DONE} state_e;

  state_e           state_q;
  logic [31:0]      buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fill_q, orig_cnt_q, dup_cnt_q;
  logic [31:0]      inst_q;
  logic             valid_q, is_dup_q, done_q;

  logic             ready_c, accept_c, push_c;
  logic [CNT_W-1:0] fill_push_c;

  // Originals live in x0-x15 / lower memory; duplicates just set the high bits.
  function automatic logic [31:0] dup_xform(input logic [31:0] i);
    logic [31:0] o;
    o = i;
    unique case (i[6:0])
      OP_R:    begin o[11] = 1'b1; o[19] = 1'b1; o[24] = 1'b1; end
      OP_I:    begin o[11] = 1'b1; o[19] = 1'b1; end
      OP_LW:   begin o[11] = 1'b1; o[30] = 1'b1; end
      OP_SW:   begin o[24] = 1'b1; o[30] = 1'b1; end
      default: o = i;
    endcase
    return o;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    ready_c     = bus.ena & ~bus.stall_in & (state_q == ORIG);
    accept_c    = ready_c & bus.ifu_valid;
    push_c      = accept_c & (bus.ifu_inst[6:0] != OP_CNOP);
    fill_push_c = fill_q + CNT_W'(push_c);
  end

  always_ff @(posedge clk) begin
    if (push_c) buf_q[wr_ptr_q] <= bus.ifu_inst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ORIG;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      orig_cnt_q <= '0;
      dup_cnt_q  <= '0;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      is_dup_q   <= 1'b0;
      done_q     <= 1'b0;
    end else if (!bus.stall_in) begin
      if (!bus.ena) begin
        // Plain pass-through; QED bookkeeping is left untouched.
        inst_q   <= bus.ifu_valid ? bus.ifu_inst : NOP_INST;
        valid_q  <= bus.ifu_valid;
        is_dup_q <= 1'b0;
      end else begin
        unique case (state_q)
          ORIG: begin
            is_dup_q <= 1'b0;
            if (accept_c) begin
              inst_q  <= push_c ? bus.ifu_inst : NOP_INST;
              valid_q <= 1'b1;
            end else begin
              inst_q  <= NOP_INST;
              valid_q <= 1'b0;
            end
            if (push_c) begin
              wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
              fill_q     <= fill_push_c;
              orig_cnt_q <= sat_inc(orig_cnt_q);
            end
            // Transition sees the fill level including this cycle's push.
            if (bus.exec_dup || (fill_push_c == CNT_W'(DEPTH))) begin
              state_q <= (fill_push_c == '0) ? DONE : DUP;
            end
          end
          DUP: begin
            inst_q    <= dup_xform(buf_q[rd_ptr_q]);
            valid_q   <= 1'b1;
            is_dup_q  <= 1'b1;
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            fill_q    <= fill_q - CNT_W'(1);
            dup_cnt_q <= sat_inc(dup_cnt_q);
            if (fill_q == CNT_W'(1)) state_q <= DONE;
          end
          default: begin
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
            is_dup_q <= 1'b0;
            done_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ifu_ready  = ready_c;
  assign bus.qed_inst   = inst_q;
  assign bus.qed_valid  = valid_q;
  assign bus.qed_is_dup = is_dup_q;
  assign bus.qed_done   = done_q;
  assign bus.orig_cnt   = orig_cnt_q;
  assign bus.dup_cnt    = dup_cnt_q;
endmodule
